spw_time_code_gen: RTL and testbench

Avalon-MM slave that supplies time-codes to the SpaceWire light core, replacing the fixed 6-bit time output port. The host can write a time value that is issued as a single tick to the core. Alternatively, a programmable prescaler can issue ticks periodically, with the time field auto-incrementing after each tick. The block holds requests until the link is running and reports overruns and tick completion, optionally via an interrupt.

---
 rtl/spw_time_code_gen.sv | 198 +++++++++++++++++++
 tb/tb_spw_time_code_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_time_code_gen.sv
// spw_time_code_gen: Avalon-MM slave that supplies SpaceWire time-codes to the
// light core. The host can write a one-shot time value. Alternatively, a
// prescaler can request periodic ticks, with the time field auto-incremented
// after each tick. Requests are held until the link is running.
//
// Optional feature macro: SPW_TIME_CODE_IRQ_EN
//   defined   -> CTRL.bit2 (irq_en) exists; irq = irq_en & (done | overrun), registered
//   undefined -> irq tied 0, CTRL.bit2 reads 0 and ignores writes
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   address           0 TIME, 1 CTRL, 2 PERIOD, 3 STATUS
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata         write data
//   readdata          combinational read data, unused bits 0
//   link_run          SpaceWire link is in Run state
//   time_out          {ctrl flags, time} to the core's time_in
//   tick_out          one-cycle tick strobe to the core's tick_in
//   irq               level interrupt
module spw_time_code_gen #(
    parameter int unsigned TIME_W   = 6,
    parameter int unsigned CTRL_W   = 2,
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic                     link_run,
    output logic [TIME_W+CTRL_W-1:0] time_out,
    output logic                     tick_out,
    output logic                     irq
);

    localparam int unsigned CodeW = TIME_W + CTRL_W;

    typedef enum logic [1:0] {StIdle, StPend, StFire} state_e;

    state_e              state_q, state_d;
    logic                tick_q, tick_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [CTRL_W-1:0]   flags_q, flags_d;
    logic                auto_en_q, auto_en_d;
    logic                auto_inc_q, auto_inc_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] presc_q, presc_d;
    logic                presc_req_q, presc_req_d;
    logic                overrun_q, overrun_d;
    logic                done_q, done_d;
    logic                irq_en_rd;

    logic wr, time_wr, ctrl_wr, period_wr, status_wr;
    logic req, counting, pending;
    logic unused_wd;

    assign wr        = chipselect & ~write_n;
    assign time_wr   = wr & (address == 2'd0);
    assign ctrl_wr   = wr & (address == 2'd1);
    assign period_wr = wr & (address == 2'd2);
    assign status_wr = wr & (address == 2'd3);
    assign unused_wd = ^writedata;

    // A host write and a prescaler request in the same cycle merge into one.
    assign req      = time_wr | presc_req_q;
    assign counting = auto_en_q & (period_q != '0);
    assign pending  = (state_q != StIdle);

    // Tick FSM
    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        case (state_q)
            StIdle: if (req) state_d = StPend;
            StPend: begin
                if (link_run) begin
                    state_d = StFire;
                    tick_d  = 1'b1;
                end
            end
            StFire:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Time value, control and status registers
    always_comb begin
        time_d     = time_q;
        flags_d    = flags_q;
        auto_en_d  = auto_en_q;
        auto_inc_d = auto_inc_q;
        period_d   = period_q;
        overrun_d  = overrun_q;
        done_d     = done_q;

        // Host value wins over the post-tick increment.
        if (time_wr) begin
            time_d  = writedata[TIME_W-1:0];
            flags_d = writedata[CodeW-1:TIME_W];
        end else if ((state_q == StFire) && auto_inc_q) begin
            time_d = time_q + TIME_W'(1);
        end

        if (ctrl_wr) begin
            auto_en_d  = writedata[0];
            auto_inc_d = writedata[1];
        end
        if (period_wr) period_d = writedata[PERIOD_W-1:0];

        // Clear first so a same-cycle set event wins.
        if (status_wr) begin
            if (writedata[1]) overrun_d = 1'b0;
            if (writedata[2]) done_d    = 1'b0;
        end
        if (req && (state_q != StIdle)) overrun_d = 1'b1;
        if (state_q == StFire)          done_d    = 1'b1;
    end

    // Prescaler: counts PERIOD..1, request registered on the reload edge so
    // consecutive requests are exactly PERIOD cycles apart.
    always_comb begin
        presc_d     = presc_q;
        presc_req_d = counting & (presc_q <= PERIOD_W'(1));
        if (period_wr) begin
            presc_d = writedata[PERIOD_W-1:0];
        end else if (ctrl_wr && writedata[0] && !auto_en_q) begin
            presc_d = period_q;
        end else if (counting) begin
            presc_d = (presc_q <= PERIOD_W'(1)) ? period_q : presc_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            tick_q      <= 1'b0;
            time_q      <= '0;
            flags_q     <= '0;
            auto_en_q   <= 1'b0;
            auto_inc_q  <= 1'b0;
            period_q    <= '0;
            presc_q     <= '0;
            presc_req_q <= 1'b0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            time_q      <= time_d;
            flags_q     <= flags_d;
            auto_en_q   <= auto_en_d;
            auto_inc_q  <= auto_inc_d;
            period_q    <= period_d;
            presc_q     <= presc_d;
            presc_req_q <= presc_req_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

`ifdef SPW_TIME_CODE_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= writedata[2];
            irq_q <= irq_en_q & (done_q | overrun_q);
        end
    end

    assign irq_en_rd = irq_en_q;
    assign irq       = irq_q;
`else
    assign irq_en_rd = 1'b0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[CodeW-1:0]    = {flags_q, time_q};
            2'd1:    readdata[2:0]          = {irq_en_rd, auto_inc_q, auto_en_q};
            2'd2:    readdata[PERIOD_W-1:0] = period_q;
            default: readdata[2:0]          = {done_q, overrun_q, pending};
        endcase
    end

    assign time_out = {flags_q, time_q};
    assign tick_out = tick_q;

endmodule

// File: tb/tb_spw_time_code_gen.sv
// Randomised self-checking bench for spw_time_code_gen. A behavioural model
// tracks tick delivery as "waiting for link" / "strobe now" and schedules
// periodic requests as absolute cycle numbers.
module tb_spw_time_code_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        link_run = 1'b0;
    logic [7:0]  time_out;
    logic        tick_out;
    logic        irq;

    spw_time_code_gen #(
        .TIME_W   (6),
        .CTRL_W   (2),
        .PERIOD_W (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .link_run   (link_run),
        .time_out   (time_out),
        .tick_out   (tick_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ticks = 0;

    // Reference model state
    logic [5:0]  m_time;
    logic [1:0]  m_flags;
    logic        m_auto_en, m_auto_inc, m_irq_en;
    logic [23:0] m_period;
    logic        m_overrun, m_done;
    logic        m_wait;   // tick requested, not yet strobed
    logic        m_tick;   // tick strobe expected this cycle
    logic        m_irq;
    int          m_cyc;
    int          m_next;   // cycle in which next periodic request is seen
    int          m_extra;  // a request already committed before a reschedule

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_time = '0; m_flags = '0; m_auto_en = 0; m_auto_inc = 0; m_irq_en = 0;
        m_period = '0; m_overrun = 0; m_done = 0; m_wait = 0; m_tick = 0; m_irq = 0;
        m_cyc = 0; m_next = -1; m_extra = -1;
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_flags, m_time};
            2'd1:    return {29'd0, m_irq_en, m_auto_inc, m_auto_en};
            2'd2:    return {8'd0, m_period};
            default: return {29'd0, m_done, m_overrun, m_wait | m_tick};
        endcase
    endfunction

    // New schedule after reload; a request due next cycle is already committed.
    task automatic resched(input int p);
        if (m_next == m_cyc + 1) m_extra = m_cyc + 1;
        m_next = (p != 0) ? m_cyc + p + 1 : -1;
    endtask

    task automatic model_step(input logic wr, input logic [1:0] a, input logic [31:0] d,
                              input logic lr);
        logic preq, wt, req, busy, n_tick, n_wait, n_irq;
        preq = (m_cyc == m_next) || (m_cyc == m_extra);
        wt   = wr && (a == 2'd0);
        req  = wt || preq;
        busy = m_wait || m_tick;
`ifdef SPW_TIME_CODE_IRQ_EN
        n_irq = m_irq_en && (m_done || m_overrun);
`else
        n_irq = 1'b0;
`endif
        if (wr && a == 2'd3) begin
            if (d[1]) m_overrun = 1'b0;
            if (d[2]) m_done = 1'b0;
        end
        if (req && busy) m_overrun = 1'b1;
        if (m_tick) m_done = 1'b1;
        if (wt) begin
            m_time  = d[5:0];
            m_flags = d[7:6];
        end else if (m_tick && m_auto_inc) begin
            m_time = m_time + 6'd1;
        end
        n_tick = m_wait && lr;
        n_wait = (m_wait && !lr) || (req && !busy);

        if (m_auto_en && m_period != 0 && m_cyc == m_next) m_next = m_cyc + int'(m_period);
        if (wr && a == 2'd1) begin
            if (d[0] && !m_auto_en) resched(int'(m_period));
            else if (!d[0] && m_auto_en) resched(0);
            m_auto_en  = d[0];
            m_auto_inc = d[1];
`ifdef SPW_TIME_CODE_IRQ_EN
            m_irq_en = d[2];
`endif
        end
        if (wr && a == 2'd2) begin
            m_period = d[23:0];
            if (m_auto_en) resched(int'(m_period));
        end
        m_tick = n_tick;
        m_wait = n_wait;
        m_irq  = n_irq;
        m_cyc++;
    endtask

    // One bus cycle: drive just after posedge, check mid-cycle, advance model.
    task automatic cycle(input logic cs, input logic [1:0] a, input logic wn,
                         input logic [31:0] d, input logic lr);
        chipselect = cs; address = a; write_n = wn; writedata = d; link_run = lr;
        @(negedge clk);
        check_eq("tick_out", 32'(tick_out), 32'(m_tick));
        check_eq("time_out", 32'(time_out), {24'd0, m_flags, m_time});
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq($sformatf("readdata[%0d]", a), readdata, model_rd(a));
        if (tick_out) n_ticks++;
        model_step(cs & ~wn, a, d, lr);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic lr);
        cycle(1'b1, a, 1'b0, d, lr);
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic lr);
        cycle(1'b1, a, 1'b1, 32'd0, lr);
    endtask

    task automatic idle(input int n, input logic lr);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b1, 32'd0, lr);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd3; writedata = 32'd0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_tick", 32'(tick_out), 32'd0);
            check_eq("rst_time", 32'(time_out), 32'd0);
            check_eq("rst_status", readdata, 32'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int t0;
    logic lr;

    initial begin
        do_reset();

        // All registers read zero after reset
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), 1'b0);
            check_eq("reset_reg", readdata, 32'd0);
        end

        // One-shot host write with link running
        wr_reg(2'd0, 32'h85, 1'b1);
        check_eq("t85_time", 32'(time_out), 32'h85);
        check_eq("t85_notick", 32'(tick_out), 32'd0);
        idle(1, 1'b1);
        check_eq("t85_tick", 32'(tick_out), 32'd1);
        idle(2, 1'b1);
        rd_reg(2'd3, 1'b1);
        check_eq("t85_done", readdata, 32'h4);
        wr_reg(2'd3, 32'h4, 1'b1);
        check_eq("t85_clr", readdata, 32'h0);

        // Held in PEND while link is down, then wrap with flags retained
        wr_reg(2'd1, 32'h2, 1'b0);
        wr_reg(2'd0, 32'hFF, 1'b0);
        t0 = n_ticks;
        idle(10, 1'b0);
        check_eq("hold_noticks", 32'(n_ticks - t0), 32'd0);
        idle(1, 1'b1);
        check_eq("hold_tick", 32'(tick_out), 32'd1);
        check_eq("hold_time", 32'(time_out), 32'hFF);
        idle(1, 1'b1);
        check_eq("wrap_time", 32'(time_out), 32'hC0);

        // Periodic ticks every 10 cycles, then stopped by PERIOD=0
        wr_reg(2'd2, 32'd10, 1'b1);
        wr_reg(2'd1, 32'h3, 1'b1);
        t0 = n_ticks;
        idle(100, 1'b1);
        check_eq("periodic_count", 32'(n_ticks - t0), 32'd9);
        wr_reg(2'd2, 32'd0, 1'b1);
        idle(5, 1'b1);
        t0 = n_ticks;
        idle(30, 1'b1);
        check_eq("period0_count", 32'(n_ticks - t0), 32'd0);
        wr_reg(2'd1, 32'h0, 1'b1);
        wr_reg(2'd3, 32'h6, 1'b1);

        // Two writes while link down: overrun, single tick
        wr_reg(2'd0, 32'h11, 1'b0);
        wr_reg(2'd0, 32'h12, 1'b0);
        rd_reg(2'd3, 1'b0);
        check_eq("ovr_status", readdata, 32'h3);
        t0 = n_ticks;
        idle(6, 1'b1);
        check_eq("ovr_one_tick", 32'(n_ticks - t0), 32'd1);
        wr_reg(2'd3, 32'h6, 1'b1);

        // W1C of overrun in the same cycle as a new overrun event: set wins
        wr_reg(2'd2, 32'd4, 1'b0);
        wr_reg(2'd1, 32'h1, 1'b0);
        for (int i = 0; i < 20 && !m_wait; i++) idle(1, 1'b0);
        for (int i = 0; i < 20 && m_cyc != m_next; i++) idle(1, 1'b0);
        wr_reg(2'd3, 32'h2, 1'b0);
        rd_reg(2'd3, 1'b0);
        check_eq("w1c_vs_set", readdata & 32'h2, 32'h2);
        wr_reg(2'd2, 32'd0, 1'b1);
        wr_reg(2'd1, 32'h0, 1'b1);
        idle(5, 1'b1);
        wr_reg(2'd3, 32'h6, 1'b1);

        // Interrupt on tick, dropped by clearing done
        wr_reg(2'd1, 32'h4, 1'b1);
        wr_reg(2'd0, 32'h20, 1'b1);
        idle(4, 1'b1);
`ifdef SPW_TIME_CODE_IRQ_EN
        check_eq("irq_set", 32'(irq), 32'd1);
`else
        check_eq("irq_tied", 32'(irq), 32'd0);
`endif
        wr_reg(2'd3, 32'h6, 1'b1);
        idle(1, 1'b1);
        check_eq("irq_clr", 32'(irq), 32'd0);

        // Reset while a tick is pending aborts it
        wr_reg(2'd0, 32'h2A, 1'b0);
        idle(2, 1'b0);
        link_run = 1'b1;
        t0 = n_ticks;
        do_reset();
        idle(5, 1'b1);
        check_eq("abort_noticks", 32'(n_ticks - t0), 32'd0);

        // Randomised traffic against the model
        lr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 9) == 0) lr = ~lr;
            if (r < 5)       cycle(1'b1, 2'd0, 1'b0, $urandom, lr);
            else if (r < 8)  cycle(1'b1, 2'd1, 1'b0, {29'd0, 3'($urandom)}, lr);
            else if (r < 10) cycle(1'b1, 2'd2, 1'b0, $urandom_range(0, 12), lr);
            else if (r < 16) cycle(1'b1, 2'd3, 1'b0, $urandom, lr);
            else if (r < 20) cycle(1'b0, 2'($urandom), 1'b0, $urandom, lr);
            else             cycle(1'b1, 2'($urandom), 1'b1, $urandom, lr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
